moving_sum_inverse: RTL and testbench



---
 rtl/moving_sum_inverse.sv | 86 ++++++++
 tb/tb_moving_sum_inverse.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/moving_sum_inverse.sv
// moving_sum_inverse
//   Rebuilds the original signed sample stream from a running sum of the
//   last DEPTH samples: x[n] = s[n] - s[n-1] + x[n-DEPTH]. A DEPTH-entry
//   history buffer holds the last DEPTH reconstructed samples. Every
//   register resets to zero, which matches the sender's reset state, so
//   the first sum after reset reconstructs correctly with no warm-up.
//
// Ports
//   system1000      clock, rising edge
//   system1000_rst  synchronous active-high reset
//   clear           synchronous state clear (keeps sync_err and out_sample)
//   in_valid        in_sum carries a new running-sum sample
//   in_sum          signed running sum s[n], SUM_WIDTH bits
//   out_valid       out_sample carries a reconstructed sample
//   out_sample      signed reconstructed sample x[n], WIDTH bits
//   sync_err        sticky: a reconstruction left the WIDTH signed range
//
// Handshake: in_valid and out_valid are single-cycle strobes with no ready.
//   Every in_valid cycle (outside reset/clear) is accepted and produces
//   exactly one out_valid pulse on the next cycle; the downstream must
//   accept every pulse. out_sample holds its value while out_valid is low.

module moving_sum_inverse #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int SUM_WIDTH = WIDTH + $clog2(DEPTH)
) (
  input  logic                 system1000,
  input  logic                 system1000_rst,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [SUM_WIDTH-1:0] in_sum,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_sample,
  output logic                 sync_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [SUM_WIDTH-1:0] s_prev;
  logic [PTR_W-1:0]     ptr;
  logic [WIDTH-1:0]     hist [DEPTH];

  logic [WIDTH-1:0]     h;
  logic [SUM_WIDTH:0]   d;
  logic [SUM_WIDTH+1:0] x;
  logic                 out_of_range;

  // Oldest sample in the window; slot is overwritten by the new one.
  assign h = hist[ptr];

  // Difference at SUM_WIDTH+1 bits and sum at SUM_WIDTH+2 bits so that no
  // intermediate overflow can hide a misalignment.
  assign d = {in_sum[SUM_WIDTH-1], in_sum} - {s_prev[SUM_WIDTH-1], s_prev};
  assign x = {d[SUM_WIDTH], d} + {{(SUM_WIDTH+2-WIDTH){h[WIDTH-1]}}, h};

  // x fits in WIDTH signed bits exactly when its bits from the WIDTH-1 sign
  // position upward are all equal.
  assign out_of_range = ~((&x[SUM_WIDTH+1:WIDTH-1]) | ~(|x[SUM_WIDTH+1:WIDTH-1]));

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      s_prev     <= '0;
      ptr        <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      sync_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else if (clear) begin
      s_prev    <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        hist[ptr]  <= x[WIDTH-1:0];
        s_prev     <= in_sum;
        ptr        <= ptr + PTR_W'(1);   // DEPTH is a power of two: wraps naturally
        out_sample <= x[WIDTH-1:0];
        if (out_of_range) sync_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_moving_sum_inverse.sv
// Directed bench for moving_sum_inverse (WIDTH=8, DEPTH=4, SUM_WIDTH=10).
// Inputs are driven 1 ns after a rising edge; outputs are sampled 1 ns
// after the following rising edge, i.e. after the edge that consumed them.

module tb_moving_sum_inverse;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [9:0] in_sum;
  logic       out_valid;
  logic [7:0] out_sample;
  logic       sync_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_exp;

  moving_sum_inverse #(.WIDTH(8), .DEPTH(4), .SUM_WIDTH(10)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .clear          (clear),
    .in_valid       (in_valid),
    .in_sum         (in_sum),
    .out_valid      (out_valid),
    .out_sample     (out_sample),
    .sync_err       (sync_err)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison helpers
  task automatic chk_s(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp_v));
      end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v)
      else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
      end
  endtask

  // Driver tasks: one call = one clock cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sum = '0;
    tick();
    rst = 1'b0;
  endtask

  // Accepted sample: next-cycle output must pulse with the queued value.
  task automatic send(input string tag, input int s);
    in_valid = 1'b1; in_sum = 10'(s);
    tick();
    in_valid = 1'b0;
    chk_b({tag, "_valid"}, out_valid, 1'b1);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      last_exp = exp_q.pop_front();
      chk_s({tag, "_sample"}, out_sample, last_exp);
    end
  endtask

  // Idle cycle: no pulse, output holds.
  task automatic idle(input string tag);
    in_valid = 1'b0;
    tick();
    chk_b({tag, "_novalid"}, out_valid, 1'b0);
    chk_s({tag, "_hold"}, out_sample, last_exp);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sum = '0;
    last_exp = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk_b("rst_valid", out_valid, 1'b0);
    chk_s("rst_sample", out_sample, 8'd0);
    chk_b("rst_err", sync_err, 1'b0);

    // Ramp with pointer wrap: 1,3,6,10,14,18 -> 1..6
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    send("ramp1", 1);
    send("ramp2", 3);
    send("ramp3", 6);
    send("ramp4", 10);
    send("ramp5", 14);
    send("ramp6", 18);
    chk_b("ramp_err", sync_err, 1'b0);
    idle("ramp_end");

    // Negative extremes: five outputs of -128
    do_reset();
    exp_q = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    send("neg1", -128);
    send("neg2", -256);
    send("neg3", -384);
    send("neg4", -512);
    send("neg5", -512);
    chk_b("neg_err", sync_err, 1'b0);

    // Valid gaps: ramp with in_valid 1,0,0,1,0,0,...
    do_reset();
    last_exp = 8'd0;
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    send("gap1", 1);  idle("gap1a"); idle("gap1b");
    send("gap2", 3);  idle("gap2a"); idle("gap2b");
    send("gap3", 6);  idle("gap3a"); idle("gap3b");
    send("gap4", 10); idle("gap4a"); idle("gap4b");
    send("gap5", 14); idle("gap5a"); idle("gap5b");
    send("gap6", 18); idle("gap6a");

    // clear mid-stream: 1,3,6 then clear then 4,9 -> 4,5
    do_reset();
    exp_q = '{8'd1, 8'd2, 8'd3};
    send("clr1", 1);
    send("clr2", 3);
    send("clr3", 6);
    clear = 1'b1; in_valid = 1'b1; in_sum = 10'd10;  // dropped: clear wins
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk_b("clr_novalid", out_valid, 1'b0);
    chk_s("clr_hold", out_sample, 8'd3);
    exp_q = '{8'd4, 8'd5};
    send("clr4", 4);
    send("clr5", 9);
    chk_b("clr_err", sync_err, 1'b0);

    // Misalignment: first sum 200 -> -56 and sticky sync_err
    do_reset();
    exp_q = '{8'hC8};
    send("mis1", 200);
    chk_b("mis_err", sync_err, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_b("mis_err_after_clear", sync_err, 1'b1);
    chk_b("mis_clear_novalid", out_valid, 1'b0);
    chk_s("mis_clear_hold", out_sample, 8'hC8);
    idle("mis_idle");
    chk_b("mis_err_idle", sync_err, 1'b1);

    // Reset mid-stream with coincident in_valid (also clears sync_err)
    exp_q = '{8'd1, 8'd2};
    send("mid1", 1);
    send("mid2", 3);
    rst = 1'b1; in_valid = 1'b1; in_sum = 10'd6;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk_b("mid_rst_valid", out_valid, 1'b0);
    chk_s("mid_rst_sample", out_sample, 8'd0);
    chk_b("mid_rst_err", sync_err, 1'b0);
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    send("re1", 1);
    send("re2", 3);
    send("re3", 6);
    send("re4", 10);
    chk_b("re_err", sync_err, 1'b0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
